// File: rtl/crc_pkg.sv
// Shared widths, lane/empty types and FSM states for the 64-to-256 packer
// that feeds the 256-bit CRC32 engine.
package crc_pkg;

  localparam int DATA_W_IN  = 64;
  localparam int DATA_W_OUT = 256;
  localparam int BYTES_OUT  = 32;
  localparam int LANES      = DATA_W_OUT / DATA_W_IN;

  typedef logic [1:0] lane_t;
  typedef logic [2:0] empty_in_t;
  typedef logic [4:0] empty_out_t;

  typedef enum logic {IDLE, PKT} state_t;

endpackage

// File: rtl/pkt_lane_acc.sv
// 256-bit accumulator: drops a 64-bit word into the selected lane and exposes
// the merged word so the top can register it in the same cycle it completes.
module pkt_lane_acc
  import crc_pkg::*;
#(
  parameter bit ZERO_FILL = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  wr,
  input  lane_t                 lane,
  input  logic [DATA_W_IN-1:0]  data,
  output logic [DATA_W_OUT-1:0] merged
);

  logic [DATA_W_OUT-1:0] acc;

  // Lanes above the one being written belong to no word yet, so zero-fill clears them.
  always_comb begin
    merged = acc;
    for (int i = 0; i < LANES; i++) begin
      if (i == int'(lane)) begin
        merged[DATA_W_OUT-1-DATA_W_IN*i -: DATA_W_IN] = data;
      end else if (ZERO_FILL && (i > int'(lane))) begin
        merged[DATA_W_OUT-1-DATA_W_IN*i -: DATA_W_IN] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (wr) begin
      acc <= merged;
    end
  end

endmodule

// File: rtl/pkt_pack_64to256.sv
// Packs a 64-bit SoP/EoP/empty packet stream into 256-bit words with the
// qualifiers, byte count and framing-error pulse the CRC engine expects.
module pkt_pack_64to256
  import crc_pkg::*;
#(
  parameter int LEN_W     = 16,
  parameter bit ZERO_FILL = 1'b1
) (
  input  logic                  i_Clk,
  input  logic                  i_RstN,
  input  logic                  i_Clr,
  input  logic [DATA_W_IN-1:0]  iv_Data,
  input  logic                  i_Dv,
  input  logic                  i_SoP,
  input  logic                  i_EoP,
  input  empty_in_t             i3_Empty,
  output logic [DATA_W_OUT-1:0] ov_Data,
  output logic                  o_Dv,
  output logic                  o_SoP,
  output logic                  o_EoP,
  output empty_out_t            o5_SoPEmpty,
  output empty_out_t            o5_EoPEmpty,
  output logic                  o_LenV,
  output logic [LEN_W-1:0]      oN_Len,
  output logic                  o_Err
);

  state_t                state;
  lane_t                 k;
  logic [LEN_W-1:0]      cnt;
  logic                  sop_pend;

  logic                  accept;
  logic                  emit;
  logic                  frame_err;
  logic                  ovf;
  lane_t                 wr_lane;
  logic [LEN_W-1:0]      base_cnt;
  logic [LEN_W:0]        cnt_sum;
  logic [LEN_W:0]        len_sum;
  logic [LEN_W-1:0]      cnt_sat;
  logic [LEN_W-1:0]      len_sat;
  logic [3:0]            len_add;
  logic [5:0]            valid_bytes;
  empty_out_t            eop_empty;
  logic [DATA_W_OUT-1:0] merged;

  // A SoP always restarts in lane 0 with a fresh count, abandoning any partial packet.
  always_comb begin
    accept      = i_Dv & (i_SoP | (state == PKT));
    wr_lane     = i_SoP ? lane_t'(0) : k;
    emit        = accept & (i_EoP | (wr_lane == lane_t'(LANES - 1)));
    base_cnt    = i_SoP ? '0 : cnt;
    len_add     = 4'd8 - {1'b0, i3_Empty};
    cnt_sum     = {1'b0, base_cnt} + (LEN_W+1)'(8);
    len_sum     = {1'b0, base_cnt} + (LEN_W+1)'(len_add);
    cnt_sat     = cnt_sum[LEN_W] ? '1 : cnt_sum[LEN_W-1:0];
    len_sat     = len_sum[LEN_W] ? '1 : len_sum[LEN_W-1:0];
    valid_bytes = {1'b0, wr_lane, 3'b000} + 6'(len_add);
    eop_empty   = empty_out_t'(6'(BYTES_OUT) - valid_bytes);
    frame_err   = i_Dv & (i_SoP ? (state == PKT) : (state == IDLE));
    ovf         = accept & i_EoP & len_sum[LEN_W];
  end

  pkt_lane_acc #(
    .ZERO_FILL(ZERO_FILL)
  ) u_acc (
    .clk    (i_Clk),
    .rst_n  (i_RstN),
    .clr    (i_Clr),
    .wr     (accept),
    .lane   (wr_lane),
    .data   (iv_Data),
    .merged (merged)
  );

  always_ff @(posedge i_Clk or negedge i_RstN) begin
    if (!i_RstN) begin
      state       <= IDLE;
      k           <= '0;
      cnt         <= '0;
      sop_pend    <= 1'b0;
      ov_Data     <= '0;
      o_Dv        <= 1'b0;
      o_SoP       <= 1'b0;
      o_EoP       <= 1'b0;
      o5_SoPEmpty <= '0;
      o5_EoPEmpty <= '0;
      o_LenV      <= 1'b0;
      oN_Len      <= '0;
      o_Err       <= 1'b0;
    end else if (i_Clr) begin
      state       <= IDLE;
      k           <= '0;
      cnt         <= '0;
      sop_pend    <= 1'b0;
      ov_Data     <= '0;
      o_Dv        <= 1'b0;
      o_SoP       <= 1'b0;
      o_EoP       <= 1'b0;
      o5_SoPEmpty <= '0;
      o5_EoPEmpty <= '0;
      o_LenV      <= 1'b0;
      oN_Len      <= '0;
      o_Err       <= 1'b0;
    end else begin
      o_Dv        <= emit;
      o_SoP       <= emit & (i_SoP | sop_pend);
      o_EoP       <= emit & i_EoP;
      o5_EoPEmpty <= (emit & i_EoP) ? eop_empty : '0;
      o_LenV      <= emit & i_EoP;
      o_Err       <= frame_err | ovf;
      if (emit) begin
        ov_Data <= merged;
      end
      if (emit & i_EoP) begin
        oN_Len <= len_sat;
      end
      // Counter saturates mid-packet; the EoP add then overflows again and flags it.
      if (accept) begin
        if (emit & i_EoP) begin
          state    <= IDLE;
          k        <= '0;
          cnt      <= '0;
          sop_pend <= 1'b0;
        end else if (emit) begin
          state    <= PKT;
          k        <= '0;
          cnt      <= cnt_sat;
          sop_pend <= 1'b0;
        end else begin
          state    <= PKT;
          k        <= wr_lane + lane_t'(1);
          cnt      <= cnt_sat;
          sop_pend <= i_SoP | sop_pend;
        end
      end
    end
  end

endmodule

// File: tb/tb_pkt_pack_64to256.sv
// Scoreboard bench for pkt_pack_64to256: a byte-level model queues expected
// 256-bit words as packets are driven; a negedge monitor pops and compares.
module tb_pkt_pack_64to256;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         clr;
  logic [63:0]  din;
  logic         dv;
  logic         sop;
  logic         eop;
  logic [2:0]   empty;
  logic [255:0] ov_Data;
  logic         o_Dv, o_SoP, o_EoP, o_LenV, o_Err;
  logic [4:0]   o5_SoPEmpty, o5_EoPEmpty;
  logic [15:0]  oN_Len;

  typedef struct {
    logic [255:0] data;
    logic         sop;
    logic         eop;
    logic [4:0]   ee;
    logic [15:0]  len;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp    = 0;
  int   n_bad    = 0;
  int   err_seen = 0;

  pkt_pack_64to256 #(.LEN_W(16), .ZERO_FILL(1'b1)) dut (
    .i_Clk       (clk),
    .i_RstN      (rst_n),
    .i_Clr       (clr),
    .iv_Data     (din),
    .i_Dv        (dv),
    .i_SoP       (sop),
    .i_EoP       (eop),
    .i3_Empty    (empty),
    .ov_Data     (ov_Data),
    .o_Dv        (o_Dv),
    .o_SoP       (o_SoP),
    .o_EoP       (o_EoP),
    .o5_SoPEmpty (o5_SoPEmpty),
    .o5_EoPEmpty (o5_EoPEmpty),
    .o_LenV      (o_LenV),
    .oN_Len      (oN_Len),
    .o_Err       (o_Err)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: every o_Dv must match the head of the expected queue.
  always @(negedge clk) begin
    exp_t x;
    if (o_Err) err_seen++;
    if (o_Dv) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("[TB] FAIL unexpected_word: got data=%h, expected no output", ov_Data);
      end else begin
        x = exp_q.pop_front();
        if (ov_Data !== x.data) begin
          n_bad++;
          $display("[TB] FAIL out_data: got %h, expected %h", ov_Data, x.data);
        end
        n_cmp++;
        if ({o_SoP, o_EoP, o5_EoPEmpty, o5_SoPEmpty, o_LenV} !== {x.sop, x.eop, x.ee, 5'd0, x.eop}) begin
          n_bad++;
          $display("[TB] FAIL out_ctrl: got sop=%b eop=%b ee=%0d se=%0d lenv=%b, expected sop=%b eop=%b ee=%0d se=0 lenv=%b",
                   o_SoP, o_EoP, o5_EoPEmpty, o5_SoPEmpty, o_LenV, x.sop, x.eop, x.ee, x.eop);
        end
        if (x.eop) begin
          n_cmp++;
          if (oN_Len !== x.len) begin
            n_bad++;
            $display("[TB] FAIL out_len: got %0d, expected %0d", oN_Len, x.len);
          end
        end
      end
    end else if (o_SoP | o_EoP | o_LenV) begin
      n_cmp++;
      n_bad++;
      $display("[TB] FAIL stray_ctrl: got sop=%b eop=%b lenv=%b with o_Dv=0, expected all 0", o_SoP, o_EoP, o_LenV);
    end
  end

  // Drives one packet; cut_words>0 sends only that many words and no EoP.
  task automatic send_pkt(input int nbytes, input int gap_max, input int cut_words);
    logic [7:0]  b[$];
    logic [63:0] wd;
    exp_t        x;
    int nw, e, sent, nout, idx;
    bit has_eop;
    nw      = (nbytes + 7) / 8;
    e       = nw * 8 - nbytes;
    has_eop = (cut_words == 0);
    sent    = has_eop ? nw : cut_words;
    for (int i = 0; i < nw * 8; i++) b.push_back(8'($urandom));
    nout = has_eop ? (nw + 3) / 4 : sent / 4;
    for (int j = 0; j < nout; j++) begin
      x.data = '0;
      for (int bi = 0; bi < 32; bi++) begin
        idx = 32 * j + bi;
        if (idx < sent * 8) x.data[255 - 8*bi -: 8] = b[idx];
      end
      x.sop = (j == 0);
      x.eop = has_eop && (j == nout - 1);
      x.ee  = x.eop ? 5'(32 - (nbytes - 32 * j)) : 5'd0;
      x.len = (nbytes > 65535) ? 16'hFFFF : 16'(nbytes);
      exp_q.push_back(x);
    end
    for (int w = 0; w < sent; w++) begin
      int g;
      g = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
      repeat (g) begin
        @(negedge clk);
        dv  = 1'b0;
        din = {$urandom, $urandom};
      end
      for (int bi = 0; bi < 8; bi++) wd[63 - 8*bi -: 8] = b[8*w + bi];
      @(negedge clk);
      dv    = 1'b1;
      din   = wd;
      sop   = (w == 0);
      eop   = has_eop && (w == nw - 1);
      empty = (has_eop && (w == nw - 1)) ? 3'(e) : 3'($urandom);
    end
    @(negedge clk);
    dv  = 1'b0;
    sop = 1'b0;
    eop = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() > 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("[TB] FAIL drain: got %0d words outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; dv = 1'b0; sop = 1'b0; eop = 1'b0; empty = '0; din = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (ov_Data !== '0) begin n_bad++; $display("[TB] FAIL reset_data: got %h, expected 0", ov_Data); end
    n_cmp++;
    if ({o_Dv, o_SoP, o_EoP, o_LenV, o_Err} !== 5'b0) begin
      n_bad++; $display("[TB] FAIL reset_ctrl: got %b, expected 00000", {o_Dv, o_SoP, o_EoP, o_LenV, o_Err});
    end
    n_cmp++;
    if ({o5_SoPEmpty, o5_EoPEmpty, oN_Len} !== 26'b0) begin
      n_bad++; $display("[TB] FAIL reset_fields: got se=%0d ee=%0d len=%0d, expected 0", o5_SoPEmpty, o5_EoPEmpty, oN_Len);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_sizes();
    send_pkt(64, 0, 0);
    send_pkt(65, 0, 0);
    send_pkt(5, 0, 0);
    drain();
  endtask

  task automatic test_long_gaps();
    send_pkt(1518, 3, 0);
    send_pkt(33, 2, 0);
    drain();
  endtask

  task automatic test_missing_eop();
    int e0 = err_seen;
    send_pkt(100, 0, 5);
    send_pkt(40, 0, 0);
    drain();
    n_cmp++;
    if (err_seen - e0 !== 1) begin
      n_bad++; $display("[TB] FAIL missing_eop_err: got %0d pulses, expected 1", err_seen - e0);
    end
  endtask

  task automatic test_stray();
    int e0 = err_seen;
    @(negedge clk); dv = 1'b1; sop = 1'b0; eop = 1'b1; empty = 3'd2; din = {$urandom, $urandom};
    @(negedge clk); dv = 1'b0; eop = 1'b0;
    @(negedge clk); dv = 1'b1; din = {$urandom, $urandom};
    @(negedge clk); dv = 1'b0;
    drain();
    n_cmp++;
    if (err_seen - e0 !== 2) begin
      n_bad++; $display("[TB] FAIL stray_err: got %0d pulses, expected 2", err_seen - e0);
    end
  endtask

  task automatic test_async_reset();
    send_pkt(100, 0, 6);
    drain();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({ov_Data, o_Dv} !== 257'b0) begin
      n_bad++; $display("[TB] FAIL async_reset: got data=%h dv=%b, expected 0", ov_Data, o_Dv);
    end
    @(negedge clk); rst_n = 1'b1;
    send_pkt(72, 0, 0);
    drain();
  endtask

  task automatic test_clear();
    send_pkt(100, 0, 6);
    drain();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    n_cmp++;
    if ({ov_Data, o_Dv} !== 257'b0) begin
      n_bad++; $display("[TB] FAIL clear: got data=%h dv=%b, expected 0", ov_Data, o_Dv);
    end
    send_pkt(24, 0, 0);
    drain();
  endtask

  task automatic test_overflow();
    int e0 = err_seen;
    send_pkt(65535, 0, 0);
    drain();
    n_cmp++;
    if (err_seen - e0 !== 0) begin
      n_bad++; $display("[TB] FAIL max_len_err: got %0d pulses, expected 0", err_seen - e0);
    end
    e0 = err_seen;
    send_pkt(65536, 0, 0);
    drain();
    n_cmp++;
    if (err_seen - e0 !== 1) begin
      n_bad++; $display("[TB] FAIL overflow_err: got %0d pulses, expected 1", err_seen - e0);
    end
  endtask

  initial begin
    test_reset();
    test_sizes();
    test_long_gaps();
    test_missing_eop();
    test_stray();
    test_async_reset();
    test_clear();
    test_overflow();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
